pipelined_barrel_shifter: RTL
=============================

// Module: pipelined_barrel_shifter
// PURPOSE
//  Parametrised, pipelined successor to the 16-bit combinational rotator.
//  - Supports four ops: rotate left, rotate right, logical right shift, arithmetic right shift.
//  - One log2 shift level per pipeline stage, with valid/ready handshakes on input and output.
//  - Sits between operand staging and the ALU writeback path of the datapath.
// PARAMETERS
//  WIDTH   16               data width; power of two, >= 2
//  LOG2W   $clog2(WIDTH)    shift-amount width = pipeline depth (derived; do not override)
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous, active-low reset
//  in_valid    in   1      input operand valid
//  in_ready    out  1      block can accept input this cycle
//  in_data     in   WIDTH  operand
//  in_amt      in   LOG2W  shift/rotate amount, 0..WIDTH-1
//  in_op       in   2      00 ROL, 01 ROR, 10 SRL, 11 SRA
//  out_valid   out  1      result valid
//  out_ready   in   1      downstream accepts result
//  out_data    out  WIDTH  result
//  out_zero    out  1      result == 0 (only when BSHIFT_ZERO_FLAG_EN is defined)
// BEHAVIOUR
//  - Pipeline: LOG2W stages, indexed k = 0..LOG2W-1.
//    - Stage k applies a shift of (1<<k) under op when amt[k] = 1; otherwise it passes data through.
//    - Each stage registers: data, op, amt, valid.
//  - Transfer rules:
//    - Input transfer: in_valid && in_ready.
//    - Output transfer: out_valid && out_ready.
//  - Stage advance:
//    - Stage k loads when !valid[k] || advance[k+1].
//    - The last stage loads when !valid[LOG2W-1] || out_ready.
//    - in_ready = advance[0].
//    - This is an elastic pipeline. A combinational path out_ready -> in_ready is permitted.
//  - Latency: exactly LOG2W cycles from input transfer to out_valid when out_ready is held 1.
//    Throughput is 1 op/cycle.
//  - Backpressure: a stalled stage holds data/op/amt/valid unchanged.
//    Bubbles collapse, so the pipeline buffers up to LOG2W ops. No loss, no duplication, order preserved.
//  - Op semantics (stage shift s = 1<<k):
//    - ROL: {d[W-1-s:0], d[W-1:W-s]}
//    - ROR: {d[s-1:0], d[W-1:s]}
//    - SRL: zeros fill the MSBs.
//    - SRA: the original sign bit d[W-1] fills the MSBs. Stage-wise SRA uses the current MSB, which
//      equals the original sign.
//  - Boundary cases:
//    - amt = 0: data unchanged for every op.
//    - amt = WIDTH-1 is the maximum. For SRL on 0x8000 it leaves a single bit at LSB.
//    - Rotation wraps modulo WIDTH by construction.
//  - Simultaneous in/out transfer with a full pipeline: accepted in the same cycle, occupancy unchanged.
//  - Reset values: all valid bits 0; data, op, amt registers 0; out_valid 0; out_data 0; out_zero 1.
//  - Reset asserted mid-operation: all in-flight ops are discarded asynchronously.
//    - out_valid falls immediately.
//    - in_ready is 1 after reset release.
//  - out_data and out_valid are driven directly from the last stage's registers (no output logic).
// CONFIGURATION
//  BSHIFT_ZERO_FLAG_EN
//  - Defined:
//    - Port out_zero exists.
//    - It is computed in the last stage's load cycle and registered alongside out_data.
//    - It is 1 iff out_data == 0, and is valid only when out_valid = 1.
//  - Undefined: port out_zero and its register are absent. All other behaviour is identical.
// TESTING (WIDTH=16, LOG2W=4, out_ready=1 unless stated)
//  1. ROL 0x8001 amt 1 -> 0x0003; ROR 0x0001 amt 4 -> 0x1000; each with out_valid exactly 4 cycles
//     after the input transfer.
//  2. SRL 0x8000 amt 15 -> 0x0001; SRA 0x8000 amt 3 -> 0xF000; SRA 0x7FF0 amt 4 -> 0x07FF;
//     any op with amt 0 on 0xA5C3 -> 0xA5C3.
//  3. Stream of 16 back-to-back random ops with in_valid held 1:
//     - in_ready stays 1 and results emerge on 16 consecutive cycles in order.
//     - Results match the reference model.
//  4. out_ready held 0 for 10 cycles during the stream:
//     - in_ready falls after 4 accepts and outputs hold stable.
//     - After release, all ops are delivered once, in order.
//  5. rst_n pulsed low while 3 ops are in flight:
//     - out_valid goes 0 during reset and no stale result appears afterwards.
//     - The first post-reset op (ROR 0x0003 amt 1) -> 0x8001.
//  6. With BSHIFT_ZERO_FLAG_EN: SRL 0x0001 amt 1 -> out_data 0x0000, out_zero 1;
//     ROL 0x0001 amt 1 -> out_zero 0.

Source files
------------

// File: rtl/pipelined_barrel_shifter.sv
// Elastic, pipelined rotate/shift unit with one log2 shift level per stage.
// Optional out_zero result flag is enabled by defining BSHIFT_ZERO_FLAG_EN.
module pipelined_barrel_shifter #(
  parameter int WIDTH = 16,
  parameter int LOG2W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_amt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef BSHIFT_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  typedef enum logic [1:0] {
    OP_ROL = 2'b00,
    OP_ROR = 2'b01,
    OP_SRL = 2'b10,
    OP_SRA = 2'b11
  } op_e;

  logic [LOG2W-1:0][WIDTH-1:0] data_q;
  logic [LOG2W-1:0][1:0]       op_q;
  logic [LOG2W-1:0][LOG2W-1:0] amt_q;
  logic [LOG2W-1:0]            valid_q;

  logic [LOG2W-1:0]            advance;
  logic [LOG2W-1:0][WIDTH-1:0] src_data;
  logic [LOG2W-1:0][1:0]       src_op;
  logic [LOG2W-1:0][LOG2W-1:0] src_amt;
  logic [LOG2W-1:0]            src_valid;
  logic [LOG2W-1:0][WIDTH-1:0] next_data;

  function automatic logic [WIDTH-1:0] shift_stage(
    input logic [WIDTH-1:0] d,
    input op_e              op,
    input int unsigned      s
  );
    logic [WIDTH-1:0] r;
    case (op)
      OP_ROL:  r = (d << s) | (d >> (WIDTH - s));
      OP_ROR:  r = (d >> s) | (d << (WIDTH - s));
      OP_SRL:  r = d >> s;
      default: r = $unsigned($signed(d) >>> s);
    endcase
    return r;
  endfunction

  // A stage may load when it is empty or everything downstream of it can move.
  always_comb begin
    logic chain;
    chain   = out_ready;
    advance = '0;
    for (int unsigned i = LOG2W; i > 0; i--) begin
      chain        = chain | ~valid_q[i-1];
      advance[i-1] = chain;
    end
  end

  always_comb begin
    src_data  = '0;
    src_op    = '0;
    src_amt   = '0;
    src_valid = '0;
    next_data = '0;
    for (int unsigned k = 0; k < LOG2W; k++) begin
      if (k == 0) begin
        src_data[k]  = in_data;
        src_op[k]    = in_op;
        src_amt[k]   = in_amt;
        src_valid[k] = in_valid;
      end else begin
        src_data[k]  = data_q[k-1];
        src_op[k]    = op_q[k-1];
        src_amt[k]   = amt_q[k-1];
        src_valid[k] = valid_q[k-1];
      end
      next_data[k] = src_amt[k][k] ? shift_stage(src_data[k], op_e'(src_op[k]), 1 << k)
                                   : src_data[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      op_q    <= '0;
      amt_q   <= '0;
    end else begin
      for (int unsigned k = 0; k < LOG2W; k++) begin
        if (advance[k]) begin
          valid_q[k] <= src_valid[k];
          data_q[k]  <= next_data[k];
          op_q[k]    <= src_op[k];
          amt_q[k]   <= src_amt[k];
        end
      end
    end
  end

`ifdef BSHIFT_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b1;
    end else if (advance[LOG2W-1]) begin
      zero_q <= (next_data[LOG2W-1] == '0);
    end
  end

  assign out_zero = zero_q;
`endif

  assign in_ready  = advance[0];
  assign out_valid = valid_q[LOG2W-1];
  assign out_data  = data_q[LOG2W-1];

endmodule
